pipeline_hazard_controller: RTL
===============================

Name: pipeline_hazard_controller

Overview:
- Central sequencer for the 5-stage in-order pipeline (IF/ID/EX/MA/WB). Issues per-stage stall/flush controls and the rs1/rs2 bypass-source selects used when the EX stage latches its operands.
- Resolves load-use interlocks, branch-mispredict flushes and multi-cycle data-memory waits.
- Orders the three when they occur together, so each mispredict produces exactly one flush.

Parameters:
- REG_ADDR_W, 5, register-file address width.
- CNT_W, 32, width of the performance counters (used only with the optional feature).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- id_rs1_addr  in  REG_ADDR_W  rs1 of instruction in ID
- id_rs2_addr  in  REG_ADDR_W  rs2 of instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_rd_addr  in  REG_ADDR_W  rd of instruction in EX
- ex_w_enable  in  1  EX instruction writes rd
- ex_is_load  in  1  EX instruction is a load
- ex_mispredict  in  1  branch in EX resolved opposite to its prediction; level, held while the branch stays in EX
- ma_rd_addr  in  REG_ADDR_W  rd in MA
- ma_w_enable  in  1  MA writes rd
- ma_is_forwardable  in  1  MA result is available this cycle (not a load)
- wb_rd_addr  in  REG_ADDR_W  rd in WB
- wb_w_enable  in  1  WB writes rd
- dmem_busy  in  1  data memory has not completed the MA access
- stall_if, stall_id, stall_ex, stall_ma  out  1 each  hold the stage register
- flush_id, flush_ex, flush_ma  out  1 each  clear the stage register to a bubble
- bypass_sel_rs1, bypass_sel_rs2  out  2 each  registered source select: 0 = regfile, 1 = EX result, 2 = MA result, 3 = reserved
- ctrl_state  out  2  current FSM state (debug)

Behaviour:
- Clock and reset: single clock clk. rst is synchronous, active-high, sampled on posedge clk.
- Reset values: all stall/flush outputs are 0, bypass selects are 0, state is RUN.
- FSM states:
  - RUN = 0
  - MEM_WAIT = 1
  - FLUSH_PEND = 2
- Transitions:
  - RUN -> MEM_WAIT when dmem_busy=1 and ex_mispredict=0.
  - RUN -> FLUSH_PEND when dmem_busy=1 and ex_mispredict=1.
  - MEM_WAIT -> FLUSH_PEND if ex_mispredict rises while dmem_busy=1.
  - MEM_WAIT -> RUN when dmem_busy=0.
  - FLUSH_PEND -> RUN when dmem_busy=0.
- Stall/flush outputs are combinational from the current state and inputs, with no added latency. Priority (highest first):
  1. dmem_busy=1: stall_if, stall_id, stall_ex and stall_ma all 1; all flushes 0.
  2. Mispredict: applies when (state=RUN and ex_mispredict=1) or (state=FLUSH_PEND and dmem_busy=0). Outputs: flush_id=1, flush_ex=1, all stalls 0. IF is redirected externally.
  3. Load-use: ex_is_load and ex_w_enable and ex_rd_addr!=0, matching a used rs in ID. Outputs: stall_if=1, stall_id=1, stall_ex=0, flush_ex=1 (bubble into EX). Lasts exactly one cycle, because the load leaves EX next cycle.
  4. Otherwise all outputs are 0.
- One flush per branch: after a mispredict flush, EX holds a bubble, so ex_mispredict drops the next cycle. The FSM never issues a second flush for the same level.
- Bypass selects, evaluated per rs with the stall/flush above applied:
  - EX match (rd!=0, w_enable, not load) -> 1.
  - Else MA match with ma_is_forwardable -> 2.
  - Else 0. A WB match selects 0 (regfile write-through).
  - Address 0 always selects 0.
- Bypass select registers: updated on posedge clk when stall_ex=0, held when stall_ex=1, cleared to 0 when flush_ex=1 or on reset.
- Mid-operation reset: rst wins over every condition; FLUSH_PEND is discarded.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN
- Defined: adds outputs perf_stall_cycles, perf_flush_count and perf_load_use_count (CNT_W each).
  - perf_stall_cycles increments every cycle stall_ex=1.
  - perf_flush_count increments every cycle flush_id=1.
  - perf_load_use_count increments once per load-use interlock.
  - All three saturate at all-ones and reset to 0.
- Undefined: the ports and logic are absent; remaining behaviour is identical.

Test Plan:
- Load-use: EX load rd=5, ID rs1=5 used -> one cycle of stall_if=1, stall_id=1, flush_ex=1. Next cycle the load is in MA (ma_is_forwardable=0) and ID rs1=5 -> no stall, bypass_sel_rs1=0 latched. The WB-stage case reads via regfile.
- ALU forward: EX rd=3 (w_enable, not load), ID rs2=3 -> no stall; bypass_sel_rs2=1 after the edge. The same with rd=0 -> sel=0.
- Mispredict in RUN: ex_mispredict=1 for one cycle -> flush_id=1, flush_ex=1 in that cycle only, bypass selects cleared, state stays RUN.
- Mispredict during memory wait: dmem_busy=1 for 4 cycles with ex_mispredict=1 from cycle 2 -> all stalls 1 for 4 cycles, state=2. The cycle dmem_busy falls gives a single flush_id/flush_ex pulse, then RUN.
- Reset mid-wait: state=FLUSH_PEND, rst=1 for one cycle -> all outputs 0, state=0, no flush after rst deasserts with dmem_busy=0 and ex_mispredict=0.
- HAZARD_PERF_CNT_EN: 3 load-use events plus a 5-cycle dmem_busy -> perf_load_use_count=3 and perf_stall_cycles=5 (load-use cycles do not stall EX).

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Hazard sequencer for the 5-stage in-order pipeline: stall/flush control and EX operand bypass selects.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
//
// state      | meaning
// RUN        | normal issue; load-use and mispredict handled in place
// MEM_WAIT   | data memory busy, whole pipe held
// FLUSH_PEND | memory busy and a mispredict is waiting; flush once the wait ends
module pipeline_hazard_controller #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  ex_w_enable,
  input  logic                  ex_is_load,
  input  logic                  ex_mispredict,
  input  logic [REG_ADDR_W-1:0] ma_rd_addr,
  input  logic                  ma_w_enable,
  input  logic                  ma_is_forwardable,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr,
  input  logic                  wb_w_enable,
  input  logic                  dmem_busy,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  stall_ex,
  output logic                  stall_ma,
  output logic                  flush_id,
  output logic                  flush_ex,
  output logic                  flush_ma,
  output logic [1:0]            bypass_sel_rs1,
  output logic [1:0]            bypass_sel_rs2,
  output logic [1:0]            ctrl_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      perf_stall_cycles,
  output logic [CNT_W-1:0]      perf_flush_count,
  output logic [CNT_W-1:0]      perf_load_use_count
`endif
);

  if (CNT_W < 1 || REG_ADDR_W < 1) begin : g_bad_params
    $error("pipeline_hazard_controller: widths must be positive");
  end

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MEM_WAIT   = 2'd1,
    FLUSH_PEND = 2'd2
  } state_t;

  state_t state, next_state;
  logic   load_use_hit, load_use_act, mispredict_act;
  logic [1:0] sel_rs1_nxt, sel_rs2_nxt;

  // A WB match deliberately yields 0: the regfile writes through to the ID read.
  function automatic logic [1:0] src_sel(input logic [REG_ADDR_W-1:0] rs);
    logic [1:0] s;
    s = 2'd0;
    if (rs == '0)                                             s = 2'd0;
    else if (ex_w_enable && !ex_is_load && ex_rd_addr == rs)  s = 2'd1;
    else if (ma_w_enable && ma_is_forwardable && ma_rd_addr == rs) s = 2'd2;
    else if (wb_w_enable && wb_rd_addr == rs)                 s = 2'd0;
    return s;
  endfunction

  assign load_use_hit = ex_is_load && ex_w_enable && (ex_rd_addr != '0) &&
                        ((id_use_rs1 && id_rs1_addr == ex_rd_addr) ||
                         (id_use_rs2 && id_rs2_addr == ex_rd_addr));

  assign sel_rs1_nxt = src_sel(id_rs1_addr);
  assign sel_rs2_nxt = src_sel(id_rs2_addr);

  always_comb begin
    next_state     = state;
    stall_if       = 1'b0;
    stall_id       = 1'b0;
    stall_ex       = 1'b0;
    stall_ma       = 1'b0;
    flush_id       = 1'b0;
    flush_ex       = 1'b0;
    flush_ma       = 1'b0;
    mispredict_act = 1'b0;
    load_use_act   = 1'b0;

    case (state)
      RUN:        if (dmem_busy) next_state = ex_mispredict ? FLUSH_PEND : MEM_WAIT;
      MEM_WAIT:   if (!dmem_busy) next_state = RUN;
                  else if (ex_mispredict) next_state = FLUSH_PEND;
      FLUSH_PEND: if (!dmem_busy) next_state = RUN;
      default:    next_state = RUN;
    endcase

    mispredict_act = (state == RUN && ex_mispredict) || (state == FLUSH_PEND && !dmem_busy);

    // Reset masks every control so nothing pending leaks out during the reset cycle.
    if (rst) begin
      next_state = RUN;
    end else if (dmem_busy) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      stall_ex = 1'b1;
      stall_ma = 1'b1;
    end else if (mispredict_act) begin
      flush_id = 1'b1;
      flush_ex = 1'b1;
    end else if (load_use_hit) begin
      stall_if     = 1'b1;
      stall_id     = 1'b1;
      flush_ex     = 1'b1;
      load_use_act = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      bypass_sel_rs1 <= 2'd0;
      bypass_sel_rs2 <= 2'd0;
    end else begin
      state <= next_state;
      if (flush_ex) begin
        bypass_sel_rs1 <= 2'd0;
        bypass_sel_rs2 <= 2'd0;
      end else if (!stall_ex) begin
        bypass_sel_rs1 <= sel_rs1_nxt;
        bypass_sel_rs2 <= sel_rs2_nxt;
      end
    end
  end

  assign ctrl_state = state;

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles   <= '0;
      perf_flush_count    <= '0;
      perf_load_use_count <= '0;
    end else begin
      if (stall_ex && perf_stall_cycles != '1)       perf_stall_cycles   <= perf_stall_cycles + CNT_ONE;
      if (flush_id && perf_flush_count != '1)        perf_flush_count    <= perf_flush_count + CNT_ONE;
      if (load_use_act && perf_load_use_count != '1) perf_load_use_count <= perf_load_use_count + CNT_ONE;
    end
  end
`endif

endmodule
